usb_rx_bit_decoder: RTL and testbench
=====================================

USB_RX_BIT_DECODER -- requirements
Module: usb_rx_bit_decoder

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 8, meaning system clocks per USB bit (96 MHz clk / 12 Mbps).
REQ-002 The block SHALL have parameter SAMPLE_POINT, default 3, meaning the bit_cnt value at which the line is sampled (range 0..CLKS_PER_BIT-1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state SHALL be updated on its rising edge.
REQ-004 The block SHALL have port n_rst, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port d_plus_sync, input, 1 bit: D+ line, already synchronised.
REQ-006 The block SHALL have port d_minus_sync, input, 1 bit: D- line, already synchronised.
REQ-007 The block SHALL have port enable, input, 1 bit: when low, the receiver is held idle.
REQ-008 The block SHALL have port rx_byte, output, 8 bits: the last completed byte, LSB first on the wire.
REQ-009 The block SHALL have port byte_ready, output, 1 bit: one-cycle pulse when rx_byte is updated.
REQ-010 The block SHALL have port shift_strobe, output, 1 bit: one-cycle pulse per unstuffed data bit.
REQ-011 The block SHALL have port decoded_bit, output, 1 bit: NRZI-decoded value of the last sampled bit.
REQ-012 The block SHALL have port eop, output, 1 bit: one-cycle pulse when SE0 is sampled.
REQ-013 The block SHALL have port stuff_error, output, 1 bit: one-cycle pulse on a bit-stuffing violation.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever state != IDLE.

Function
REQ-015 Line decode SHALL be: J = (D+,D-) = (1,0); K = (0,1); SE0 = (0,0); SE1 = (1,1), which SHALL be treated as J.
REQ-016 The FSM states SHALL be IDLE, RECEIVE, WAIT_EOP, EOP_J.
REQ-017 In IDLE, bit_cnt, ones_cnt and bit_idx SHALL be 0, and prev_sample SHALL be J.
REQ-018 A J->K transition in IDLE SHALL move the FSM to RECEIVE, with bit_cnt set to 0 on that edge.
REQ-019 In RECEIVE, bit_cnt SHALL increment modulo CLKS_PER_BIT each clock, and any change of d_plus_sync SHALL reload it to 0 (resync; the resync takes priority over the increment).
REQ-020 When bit_cnt == SAMPLE_POINT in RECEIVE, the line SHALL be sampled.
REQ-021 If the sample is SE0, the block SHALL pulse eop, discard any partial byte (bit_idx := 0, no byte_ready), and move to EOP_J.
REQ-022 If the sample is not SE0, decoded_bit SHALL be 1 when it equals prev_sample and 0 otherwise, and prev_sample SHALL then be updated.
REQ-023 Unstuffing: if ones_cnt == 6, the sampled bit is a stuff bit; it SHALL NOT be shifted and ones_cnt := 0.
REQ-024 If that stuff bit decodes to 1, the block SHALL pulse stuff_error, clear bit_idx, and move to WAIT_EOP.
REQ-025 For a data bit, the block SHALL pulse shift_strobe and shift it into shift_reg[7], shifting right.
REQ-026 For a data bit, ones_cnt SHALL be incremented on 1 and cleared on 0.
REQ-027 For a data bit, bit_idx SHALL be incremented modulo 8.
REQ-028 When bit_idx wraps 7->0, rx_byte SHALL load the completed byte and byte_ready SHALL pulse in the clock after the sampling clock (latency 1).
REQ-029 In WAIT_EOP, the FSM SHALL wait until SE0 is present at a sample point, then move to EOP_J with no eop pulse.
REQ-030 In EOP_J, the FSM SHALL return to IDLE on the first clock the line is J.
REQ-031 enable low SHALL force IDLE on the next clock, suppressing all pulses in that clock, with rx_byte held.
REQ-032 byte_ready and eop SHALL never be asserted in the same clock.

Reset
REQ-033 While n_rst is low, the block SHALL hold state = IDLE; rx_byte, shift_reg, bit_cnt, bit_idx and ones_cnt = 0; and byte_ready, shift_strobe, eop and stuff_error = 0.
REQ-034 While n_rst is low, decoded_bit SHALL be 1, prev_sample SHALL be J and busy SHALL be 0.
REQ-035 Reset asserted mid-packet SHALL abort immediately with no pulses, and after release the block SHALL wait for a fresh J->K.

Verification
REQ-036 SYNC KJKJKJKK at 8 clk/bit -> byte_ready with rx_byte = 0x80, 8 shift_strobe pulses.
REQ-037 SYNC then data 0xFF (seven 1s -> stuff bit present) -> rx_byte = 0xFF; only 8 data strobes; no stuff_error.
REQ-038 Six 1s followed by a non-toggling (decoded-1) bit -> stuff_error pulse; then SE0, J -> busy falls, no eop.
REQ-039 SYNC, 3 data bits, then SE0 x2 bits, J -> eop pulse; no byte_ready; IDLE.
REQ-040 Bit periods alternating 7 and 9 clocks for 32 bits -> correct bytes (resync verified).
REQ-041 n_rst pulse low mid-byte -> outputs cleared asynchronously; next packet decodes correctly.

Source files
------------

// File: rtl/usb_rx_bit_decoder.sv
// -----------------------------------------------------------------------------
// usb_rx_bit_decoder
//
// Full-speed USB receive bit layer. Recovers bit timing from the synchronised
// D+/D- pair by free-running a per-bit clock counter that realigns on every
// D+ edge. It samples once per bit, undoes NRZI, removes stuffed bits and
// assembles bytes LSB first. It also reports end-of-packet (SE0) and
// bit-stuffing violations.
//
// Parameters
//   CLKS_PER_BIT  system clocks per USB bit (96 MHz / 12 Mbps = 8)
//   SAMPLE_POINT  bit_cnt value at which the line is sampled (0..CLKS_PER_BIT-1)
//
// Ports
//   clk           system clock, rising edge
//   n_rst         asynchronous active-low reset
//   d_plus_sync   synchronised D+
//   d_minus_sync  synchronised D-
//   enable        low holds the receiver idle
//   rx_byte       last completed byte
//   byte_ready    one-cycle pulse when rx_byte updates
//   shift_strobe  one-cycle pulse per unstuffed data bit
//   decoded_bit   NRZI-decoded value of the last sampled bit
//   eop           one-cycle pulse when SE0 is sampled while receiving
//   stuff_error   one-cycle pulse on a bit-stuffing violation
//   busy          high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module usb_rx_bit_decoder #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_POINT = 3
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       d_plus_sync,
    input  logic       d_minus_sync,
    input  logic       enable,
    output logic [7:0] rx_byte,
    output logic       byte_ready,
    output logic       shift_strobe,
    output logic       decoded_bit,
    output logic       eop,
    output logic       stuff_error,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] SAMPLE  = CW'(SAMPLE_POINT);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RECEIVE  = 2'd1,
        WAIT_EOP = 2'd2,
        EOP_J    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [2:0]    ones_cnt_q, ones_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          prev_sample_q, prev_sample_d;   // line level of last sample, 1 = J
    logic [7:0]    shift_reg_q, shift_reg_d;
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          byte_ready_q, byte_ready_d;
    logic          shift_strobe_q, shift_strobe_d;
    logic          decoded_bit_q, decoded_bit_d;
    logic          eop_q, eop_d;
    logic          stuff_error_q, stuff_error_d;

    // Previous-clock line history. dp_prev_q drives resync; j_seen_q arms the
    // start-of-packet detector. j_seen_q resets to 0 so a line that is already
    // K when reset is released cannot be mistaken for a fresh J->K edge.
    logic          dp_prev_q;
    logic          j_seen_q;

    // SE1 carries D+ high, so "line is J" reduces to D+ alone.
    logic          line_j;
    logic          line_k;
    logic          line_se0;
    logic          dp_changed;
    logic          sample_now;
    logic          sample_bit;
    logic [CW-1:0] cnt_next;
    logic [7:0]    byte_next;

    assign line_j     = d_plus_sync;
    assign line_k     = !d_plus_sync && d_minus_sync;
    assign line_se0   = !d_plus_sync && !d_minus_sync;
    assign dp_changed = (d_plus_sync != dp_prev_q);
    assign sample_now = (bit_cnt_q == SAMPLE);

    // NRZI: no level change means 1.
    assign sample_bit = (d_plus_sync == prev_sample_q);
    assign byte_next  = {sample_bit, shift_reg_q[7:1]};

    // An edge on D+ realigns the bit clock and takes priority over counting.
    assign cnt_next = dp_changed           ? '0 :
                      (bit_cnt_q == CNT_MAX) ? '0 :
                      bit_cnt_q + CW'(1);

    always_comb begin
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        ones_cnt_d     = ones_cnt_q;
        bit_idx_d      = bit_idx_q;
        prev_sample_d  = prev_sample_q;
        shift_reg_d    = shift_reg_q;
        rx_byte_d      = rx_byte_q;
        decoded_bit_d  = decoded_bit_q;
        byte_ready_d   = 1'b0;
        shift_strobe_d = 1'b0;
        eop_d          = 1'b0;
        stuff_error_d  = 1'b0;

        if (!enable) begin
            state_d       = IDLE;
            bit_cnt_d     = '0;
            ones_cnt_d    = '0;
            bit_idx_d     = '0;
            prev_sample_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    bit_cnt_d     = '0;
                    ones_cnt_d    = '0;
                    bit_idx_d     = '0;
                    prev_sample_d = 1'b1;
                    if (j_seen_q && line_k) begin
                        state_d = RECEIVE;
                    end
                end

                RECEIVE: begin
                    bit_cnt_d = cnt_next;
                    if (sample_now) begin
                        if (line_se0) begin
                            // End of packet: any partial byte is dropped.
                            eop_d      = 1'b1;
                            bit_idx_d  = '0;
                            ones_cnt_d = '0;
                            state_d    = EOP_J;
                        end else begin
                            decoded_bit_d = sample_bit;
                            prev_sample_d = d_plus_sync;
                            if (ones_cnt_q == 3'd6) begin
                                // Stuffed bit: never shifted, must be a 0.
                                ones_cnt_d = '0;
                                if (sample_bit) begin
                                    stuff_error_d = 1'b1;
                                    bit_idx_d     = '0;
                                    state_d       = WAIT_EOP;
                                end
                            end else begin
                                shift_strobe_d = 1'b1;
                                shift_reg_d    = byte_next;
                                ones_cnt_d     = sample_bit ? ones_cnt_q + 3'd1 : 3'd0;
                                bit_idx_d      = bit_idx_q + 3'd1;
                                if (bit_idx_q == 3'd7) begin
                                    rx_byte_d    = byte_next;
                                    byte_ready_d = 1'b1;
                                end
                            end
                        end
                    end
                end

                WAIT_EOP: begin
                    // Keep bit timing alive so SE0 is only accepted at a sample point.
                    bit_cnt_d = cnt_next;
                    if (sample_now && line_se0) begin
                        state_d = EOP_J;
                    end
                end

                EOP_J: begin
                    bit_cnt_d = '0;
                    if (line_j) begin
                        state_d       = IDLE;
                        ones_cnt_d    = '0;
                        bit_idx_d     = '0;
                        prev_sample_d = 1'b1;
                    end
                end

                default: begin
                    state_d       = IDLE;
                    bit_cnt_d     = '0;
                    ones_cnt_d    = '0;
                    bit_idx_d     = '0;
                    prev_sample_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q        <= IDLE;
            bit_cnt_q      <= '0;
            ones_cnt_q     <= '0;
            bit_idx_q      <= '0;
            prev_sample_q  <= 1'b1;
            shift_reg_q    <= '0;
            rx_byte_q      <= '0;
            byte_ready_q   <= 1'b0;
            shift_strobe_q <= 1'b0;
            decoded_bit_q  <= 1'b1;
            eop_q          <= 1'b0;
            stuff_error_q  <= 1'b0;
            dp_prev_q      <= 1'b1;
            j_seen_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            ones_cnt_q     <= ones_cnt_d;
            bit_idx_q      <= bit_idx_d;
            prev_sample_q  <= prev_sample_d;
            shift_reg_q    <= shift_reg_d;
            rx_byte_q      <= rx_byte_d;
            byte_ready_q   <= byte_ready_d;
            shift_strobe_q <= shift_strobe_d;
            decoded_bit_q  <= decoded_bit_d;
            eop_q          <= eop_d;
            stuff_error_q  <= stuff_error_d;
            dp_prev_q      <= d_plus_sync;
            j_seen_q       <= line_j;
        end
    end

    assign rx_byte      = rx_byte_q;
    assign byte_ready   = byte_ready_q;
    assign shift_strobe = shift_strobe_q;
    assign decoded_bit  = decoded_bit_q;
    assign eop          = eop_q;
    assign stuff_error  = stuff_error_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_usb_rx_bit_decoder.sv
module tb_usb_rx_bit_decoder;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       dp, dm, en;
    logic [7:0] rx_byte;
    logic       byte_ready, shift_strobe, decoded_bit, eop, stuff_error, busy;

    always #5 clk = ~clk;

    usb_rx_bit_decoder #(.CLKS_PER_BIT(8), .SAMPLE_POINT(3)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .d_plus_sync  (dp),
        .d_minus_sync (dm),
        .enable       (en),
        .rx_byte      (rx_byte),
        .byte_ready   (byte_ready),
        .shift_strobe (shift_strobe),
        .decoded_bit  (decoded_bit),
        .eop          (eop),
        .stuff_error  (stuff_error),
        .busy         (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int         cnt_byte, cnt_strobe, cnt_eop, cnt_serr;
    logic [7:0] last_byte;
    logic [7:0] seen[$];
    logic       lvl;   // current NRZI line level, 1 = J

    // Pulse monitor, sampling mid-cycle.
    always @(negedge clk) begin
        if (byte_ready) begin
            cnt_byte++;
            last_byte = rx_byte;
            seen.push_back(rx_byte);
        end
        if (shift_strobe) cnt_strobe++;
        if (eop)          cnt_eop++;
        if (stuff_error)  cnt_serr++;
        if (byte_ready && eop) begin
            n_tests++;
            n_fail++;
            $display("FAIL byte_ready_eop_overlap: got both high, required never together");
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        cnt_byte   = 0;
        cnt_strobe = 0;
        cnt_eop    = 0;
        cnt_serr   = 0;
        last_byte  = 8'h00;
        seen.delete();
    endtask

    // Called at a falling edge; holds the level for n clocks.
    task automatic drive(input logic p, input logic m, input int n);
        dp = p;
        dm = m;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input int n);
        if (!b) lvl = ~lvl;
        drive(lvl, ~lvl, n);
    endtask

    task automatic send_sync(input int n);
        for (int i = 0; i < 7; i++) send_bit(1'b0, n);
        send_bit(1'b1, n);
    endtask

    task automatic send_byte(input logic [7:0] v, input int n);
        for (int i = 0; i < 8; i++) send_bit(v[i], n);
    endtask

    task automatic send_eop(input int n);
        drive(1'b0, 1'b0, 2 * n);
        lvl = 1'b1;
        drive(1'b1, 1'b0, n);
    endtask

    typedef struct {
        logic [7:0] data;
        int         period;
        logic [7:0] exp_byte;
        int         exp_strobes;
        int         exp_bytes;
        logic       exp_dec;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] stream;
        logic [7:0]  b1, b2, b3;

        vecs[0] = '{data: 8'h00, period: 8, exp_byte: 8'h00, exp_strobes: 16, exp_bytes: 2, exp_dec: 1'b0};
        vecs[1] = '{data: 8'h55, period: 9, exp_byte: 8'h55, exp_strobes: 16, exp_bytes: 2, exp_dec: 1'b0};
        vecs[2] = '{data: 8'hA5, period: 8, exp_byte: 8'hA5, exp_strobes: 16, exp_bytes: 2, exp_dec: 1'b1};
        vecs[3] = '{data: 8'h3C, period: 8, exp_byte: 8'h3C, exp_strobes: 16, exp_bytes: 2, exp_dec: 1'b0};
        vecs[4] = '{data: 8'h81, period: 8, exp_byte: 8'h81, exp_strobes: 16, exp_bytes: 2, exp_dec: 1'b1};
        vecs[5] = '{data: 8'h00, period: 7, exp_byte: 8'h00, exp_strobes: 16, exp_bytes: 2, exp_dec: 1'b0};

        n_rst = 1'b0;
        dp    = 1'b1;
        dm    = 1'b0;
        en    = 1'b1;
        lvl   = 1'b1;
        clear_counts();
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_rx_byte",      rx_byte,      8'h00);
        check("rst_byte_ready",   byte_ready,   1'b0);
        check("rst_shift_strobe", shift_strobe, 1'b0);
        check("rst_eop",          eop,          1'b0);
        check("rst_stuff_error",  stuff_error,  1'b0);
        check("rst_decoded_bit",  decoded_bit,  1'b1);
        check("rst_busy",         busy,         1'b0);

        n_rst = 1'b1;
        drive(1'b1, 1'b0, 6);

        // SYNC alone -> 0x80
        clear_counts();
        send_sync(8);
        send_eop(8);
        drive(1'b1, 1'b0, 4);
        check("sync_bytes",   cnt_byte,   1);
        check("sync_value",   last_byte,  8'h80);
        check("sync_strobes", cnt_strobe, 8);
        check("sync_eop",     cnt_eop,    1);
        check("sync_busy",    busy,       1'b0);

        // Table of single-byte packets
        for (int v = 0; v < 6; v++) begin
            clear_counts();
            send_sync(vecs[v].period);
            send_byte(vecs[v].data, vecs[v].period);
            send_eop(vecs[v].period);
            drive(1'b1, 1'b0, 4);
            check($sformatf("vec%0d_bytes", v),   cnt_byte,    vecs[v].exp_bytes);
            check($sformatf("vec%0d_value", v),   last_byte,   vecs[v].exp_byte);
            check($sformatf("vec%0d_strobes", v), cnt_strobe,  vecs[v].exp_strobes);
            check($sformatf("vec%0d_eop", v),     cnt_eop,     1);
            check($sformatf("vec%0d_serr", v),    cnt_serr,    0);
            check($sformatf("vec%0d_dec", v),     decoded_bit, vecs[v].exp_dec);
            check($sformatf("vec%0d_busy", v),    busy,        1'b0);
        end

        // 0xFF: sync's trailing 1 plus five data 1s forces a stuffed 0
        clear_counts();
        send_sync(8);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 8);
        send_bit(1'b0, 8);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 8);
        send_eop(8);
        drive(1'b1, 1'b0, 4);
        check("ff_bytes",   cnt_byte,   2);
        check("ff_value",   last_byte,  8'hFF);
        check("ff_strobes", cnt_strobe, 16);
        check("ff_serr",    cnt_serr,   0);
        check("ff_eop",     cnt_eop,    1);

        // Stuff violation: six 1s then a non-toggling bit
        clear_counts();
        send_sync(8);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 8);
        send_bit(1'b1, 8);
        check("serr_pulse",   cnt_serr,   1);
        check("serr_busy_hi", busy,       1'b1);
        send_eop(8);
        drive(1'b1, 1'b0, 4);
        check("serr_strobes", cnt_strobe, 13);
        check("serr_bytes",   cnt_byte,   1);
        check("serr_no_eop",  cnt_eop,    0);
        check("serr_busy_lo", busy,       1'b0);

        // Partial byte then EOP
        clear_counts();
        send_sync(8);
        send_bit(1'b1, 8);
        send_bit(1'b0, 8);
        send_bit(1'b1, 8);
        send_eop(8);
        drive(1'b1, 1'b0, 4);
        check("part_eop",     cnt_eop,    1);
        check("part_bytes",   cnt_byte,   1);
        check("part_strobes", cnt_strobe, 11);
        check("part_rx_held", rx_byte,    8'h80);
        check("part_busy",    busy,       1'b0);

        // Alternating 7/9-clock bits over 32 bits
        clear_counts();
        stream = {8'h5A, 8'h3C, 8'hA5, 8'h80};
        for (int i = 0; i < 32; i++) send_bit(stream[i], (i % 2 == 1) ? 9 : 7);
        send_eop(8);
        drive(1'b1, 1'b0, 4);
        b1 = (seen.size() > 1) ? seen[1] : 8'hxx;
        b2 = (seen.size() > 2) ? seen[2] : 8'hxx;
        b3 = (seen.size() > 3) ? seen[3] : 8'hxx;
        check("resync_bytes", cnt_byte, 4);
        check("resync_b1",    b1,       8'hA5);
        check("resync_b2",    b2,       8'h3C);
        check("resync_b3",    b3,       8'h5A);
        check("resync_eop",   cnt_eop,  1);

        // enable low mid-packet
        clear_counts();
        send_sync(8);
        send_bit(1'b1, 8);
        send_bit(1'b0, 8);
        send_bit(1'b1, 8);
        en = 1'b0;
        @(negedge clk);
        check("en_busy",    busy, 1'b0);
        lvl = 1'b1;
        drive(1'b1, 1'b0, 4);
        en = 1'b1;
        drive(1'b1, 1'b0, 8);
        check("en_bytes",   cnt_byte,   1);
        check("en_strobes", cnt_strobe, 11);
        check("en_eop",     cnt_eop,    0);
        check("en_rx_held", rx_byte,    8'h80);

        // Asynchronous reset mid-byte
        clear_counts();
        send_sync(8);
        send_bit(1'b1, 8);
        send_bit(1'b0, 8);
        send_bit(1'b1, 8);
        check("pre_rst_busy", busy, 1'b1);
        #3 n_rst = 1'b0;
        #1;
        check("arst_busy",    busy,        1'b0);
        check("arst_rx_byte", rx_byte,     8'h00);
        check("arst_strobe",  shift_strobe, 1'b0);
        check("arst_dec",     decoded_bit, 1'b1);
        lvl = 1'b0;
        dp  = 1'b0;
        dm  = 1'b1;
        @(negedge clk);
        n_rst = 1'b1;
        drive(1'b0, 1'b1, 5);
        check("arst_no_false_start", busy, 1'b0);
        lvl = 1'b1;
        drive(1'b1, 1'b0, 8);
        clear_counts();
        send_sync(8);
        send_byte(8'h3C, 8);
        send_eop(8);
        drive(1'b1, 1'b0, 4);
        check("post_rst_bytes", cnt_byte,  2);
        check("post_rst_value", last_byte, 8'h3C);
        check("post_rst_busy",  busy,      1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
